// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the LSU (p0)
// and the loader/DMA (p1); does lane steering, load extension and access checks.
module dmem_arbiter #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [1:0]        p0_size,
   input  logic              p0_uns,
   input  logic [31:0]       p0_addr,
   input  logic [31:0]       p0_wdata,
   output logic              p0_gnt,
   output logic              p0_done,
   output logic              p0_err,
   output logic [31:0]       p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [1:0]        p1_size,
   input  logic              p1_uns,
   input  logic [31:0]       p1_addr,
   input  logic [31:0]       p1_wdata,
   output logic              p1_gnt,
   output logic              p1_done,
   output logic              p1_err,
   output logic [31:0]       p1_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state, state_nxt;
   logic        ptr;          // last granted port
   logic        accept, win;
   logic        sel_we, sel_uns, sel_err;
   logic [1:0]  sel_size;
   logic [31:0] sel_addr, sel_wdata, sel_wd;
   logic [3:0]  sel_be;

   // transaction context held from accept to completion
   logic        own, t_we, t_uns, t_err;
   logic [1:0]  t_size, t_off;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   logic [31:0] load_val;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = (state == IDLE) && (p0_req || p1_req);
      win       = (p0_req && p1_req) ? ~ptr : p1_req;
      case (state)
         IDLE:    if (accept) state_nxt = ACCESS;
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sel_we    = win ? p1_we    : p0_we;
      sel_size  = win ? p1_size  : p0_size;
      sel_uns   = win ? p1_uns   : p0_uns;
      sel_addr  = win ? p1_addr  : p0_addr;
      sel_wdata = win ? p1_wdata : p0_wdata;
      sel_err   = (sel_size == 2'b11) ||
                  (sel_size == 2'b01 && sel_addr[0]) ||
                  (sel_size == 2'b10 && sel_addr[1:0] != 2'b00) ||
                  (|sel_addr[31:ADDR_W+2]);
      sel_be = 4'b0000;
      sel_wd = sel_wdata;
      case (sel_size)
         2'b00: begin
            sel_be = 4'b0001 << sel_addr[1:0];
            sel_wd = {4{sel_wdata[7:0]}};
         end
         2'b01: begin
            sel_be = sel_addr[1] ? 4'b1100 : 4'b0011;
            sel_wd = {2{sel_wdata[15:0]}};
         end
         2'b10:   sel_be = 4'b1111;
         default: sel_be = 4'b0000;
      endcase
   end

   always_comb begin
      case (t_off)
         2'd0:    ld_b = mem_rdata[7:0];
         2'd1:    ld_b = mem_rdata[15:8];
         2'd2:    ld_b = mem_rdata[23:16];
         default: ld_b = mem_rdata[31:24];
      endcase
      ld_h = t_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (t_size)
         2'b00:   load_val = {{24{ld_b[7]  & ~t_uns}}, ld_b};
         2'b01:   load_val = {{16{ld_h[15] & ~t_uns}}, ld_h};
         default: load_val = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= 1'b1;
         own       <= 1'b0;
         t_we      <= 1'b0;
         t_uns     <= 1'b0;
         t_err     <= 1'b0;
         t_size    <= 2'b00;
         t_off     <= 2'b00;
         p0_gnt    <= 1'b0;
         p1_gnt    <= 1'b0;
         p0_done   <= 1'b0;
         p1_done   <= 1'b0;
         p0_err    <= 1'b0;
         p1_err    <= 1'b0;
         p0_rdata  <= '0;
         p1_rdata  <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         p0_gnt    <= 1'b0;
         p1_gnt    <= 1'b0;
         p0_done   <= 1'b0;
         p1_done   <= 1'b0;
         p0_err    <= 1'b0;
         p1_err    <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if (accept) begin
            own    <= win;
            ptr    <= win;
            t_we   <= sel_we;
            t_uns  <= sel_uns;
            t_err  <= sel_err;
            t_size <= sel_size;
            t_off  <= sel_addr[1:0];
            if (win) p1_gnt <= 1'b1;
            else     p0_gnt <= 1'b1;
            // faulty requests never reach the memory
            if (!sel_err) begin
               mem_en    <= 1'b1;
               mem_we    <= sel_we;
               mem_be    <= sel_be;
               mem_addr  <= sel_addr[ADDR_W+1:2];
               mem_wdata <= sel_wd;
            end
         end
         if (state == RESP) begin
            if (own) begin
               p1_done <= 1'b1;
               p1_err  <= t_err;
               if (t_err)      p1_rdata <= '0;
               else if (!t_we) p1_rdata <= load_val;
            end else begin
               p0_done <= 1'b1;
               p0_err  <= t_err;
               if (t_err)      p0_rdata <= '0;
               else if (!t_we) p0_rdata <= load_val;
            end
         end
      end
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single-port data memory between two requesters: port 0 (pipeline load/store unit) and port 1 (loader/debug DMA).
- Arbitrates round-robin and sequences one memory access per transaction.
- Performs byte/halfword/word lane steering, load sign or zero extension, and alignment/range checking, so the memory array itself only sees word-indexed, byte-enabled accesses.

## Interface
Parameters:
- ADDR_W, 10, word-index width of the memory (1024 words)

Ports (pN = p0, p1; all pN signals are duplicated per port):
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- pN_req  in  1  request; held with its fields stable until pN_gnt
- pN_we  in  1  1 = store, 0 = load
- pN_size  in  2  00 byte, 01 half, 10 word; 11 is illegal
- pN_uns  in  1  load is zero-extended (LBU/LHU)
- pN_addr  in  32  byte address
- pN_wdata  in  32  store data, right-aligned
- pN_gnt  out  1  one-cycle pulse: request captured
- pN_done  out  1  one-cycle pulse: transaction complete
- pN_err  out  1  qualifies pN_done: misaligned, out-of-range or illegal size
- pN_rdata  out  32  load result; updated only with pN_done
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable
- mem_be  out  4  byte enables
- mem_addr  out  ADDR_W  word index
- mem_wdata  out  32  lane-steered write data
- mem_rdata  in  32  read data, valid one cycle after mem_en (synchronous read)

## Operation
- State machine: IDLE → ACCESS → RESP → IDLE, unconditionally after leaving IDLE.
- Accept: in IDLE, if any pN_req is high, the winner's fields are latched, the state moves to ACCESS, and the round-robin pointer is set to the winner.
  - Winner with both requesting = the port not granted last.
  - Pointer resets to 1, so port 0 wins the first tie.
  - Requests are ignored outside IDLE.
- Error: err is set at accept if any of the following holds:
  - size = 11
  - half access with addr[0] = 1
  - word access with addr[1:0] ≠ 00
  - addr[31:ADDR_W+2] ≠ 0
- Store steering:
  - byte: mem_wdata = {4{wdata[7:0]}}, mem_be = 0001 << addr[1:0]
  - half: mem_wdata = {2{wdata[15:0]}}, mem_be = addr[1] ? 1100 : 0011
  - word: mem_wdata = wdata, mem_be = 1111
- mem_addr = addr[ADDR_W+1:2].
- Load: mem_be holds the same lane mask; mem_we = 0. In RESP the arbiter selects the lane by addr[1:0] (byte) or addr[1] (half), then sign-extends, or zero-extends if uns, into the owner's pN_rdata.
- Store completion: pN_rdata is left unchanged on a store.
- Error transaction: no memory access (mem_en stays 0 in ACCESS). Completes with pN_done = pN_err = 1 and pN_rdata = 0.

## Timing
- All outputs are registered.
- Reset values: all gnt/done/err = 0, all rdata = 0, mem_en = mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0, state IDLE, pointer = 1.
- Cycle numbering, with accept at the edge ending cycle T0:
  - T1 (ACCESS): pN_gnt = 1, mem_en/we/be/addr/wdata valid.
  - T2 (RESP): mem_rdata valid, memory outputs return to 0.
  - T3 (IDLE): pN_done = 1, pN_err, pN_rdata valid.
- A new accept can occur in T3 itself, so maximum throughput is one transaction per 3 cycles.
- Requester rule: after pN_gnt is sampled, req is dropped or changed to the next request.
- The losing requester keeps req high and is served next: accept in T3, gnt in T4.
- Simultaneous done of one port and accept of the other is legal.
- Reset mid-transaction: immediate return to reset values. The pending transaction is dropped with no done, and a store in ACCESS whose edge is pre-empted is not guaranteed.

## Test plan
- p0 SW addr 0x10, wdata 0xDEADBEEF, then p0 LW 0x10 → T1 mem_en=1 mem_we=1 mem_be=1111 mem_addr=4. Load gives p0_done at T3 with p0_rdata=0xDEADBEEF, err=0.
- p1 SB addr 0x13, wdata 0x80, then LB and LBU at 0x13 → mem_be=1000, mem_wdata=0x80808080. LB returns 0xFFFFFF80, LBU returns 0x00000080.
- SH addr 0x22 wdata 0x8001, then LH 0x22 → mem_be=1100, rdata=0xFFFF8001. LW at 0x22 → err=1, done=1, rdata=0, mem_en never asserted.
- p0 and p1 request together from reset → p0 granted first (T1), p1 granted at T4. Repeated simultaneous requests alternate p1, p0, p1.
- LW addr 0x1000 (ADDR_W=10) and size=11 → each completes with err=1 and no mem_en.
- Assert rst during ACCESS of a p1 load → all outputs 0 the same cycle, no p1_done. After release, a new p0 request is accepted with p0 winning the tie.
